// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants for the instruction-fetch PC stage: default
//            address width, reset PC, sequential step size and the encoding
//            of the next-PC select input.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Default geometry of the program counter.
  localparam int unsigned FETCH_ADDRESS_BITS = 16;
  localparam int unsigned FETCH_RESET_PC     = 0;
  localparam int unsigned FETCH_PC_STEP      = 4;

  // Encoding of next_PC_select.
  localparam logic SEL_SEQ    = 1'b0;
  localparam logic SEL_TARGET = 1'b1;

  // A target is misaligned when it is not on a 4-byte instruction boundary.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_mux
// Purpose  : Combinational next-PC selection: either the current PC advanced
//            by PC_STEP (wrapping modulo 2^ADDRESS_BITS) or the redirect
//            target, passed through unmodified.
// Ports    : pc        - current PC register value
//            select    - SEL_SEQ / SEL_TARGET
//            target_pc - redirect address
//            next_pc   - value the PC register loads on the next edge
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_mux
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = FETCH_ADDRESS_BITS,
  parameter int unsigned PC_STEP      = FETCH_PC_STEP
) (
  input  logic [ADDRESS_BITS-1:0] pc,
  input  logic                    select,
  input  logic [ADDRESS_BITS-1:0] target_pc,
  output logic [ADDRESS_BITS-1:0] next_pc
);

  localparam logic [ADDRESS_BITS-1:0] STEP = ADDRESS_BITS'(PC_STEP);

  // The sum is kept at ADDRESS_BITS so overflow simply wraps with no carry.
  logic [ADDRESS_BITS-1:0] seq_pc;
  assign seq_pc = pc + STEP;

  always_comb begin
    next_pc = seq_pc;
    if (select == SEL_TARGET) begin
      next_pc = target_pc;
    end
  end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Purpose  : Instruction-fetch program-counter stage. Holds the PC register,
//            advances it by PC_STEP each clock or loads a redirect target
//            when next_PC_select is high. PC is a pure register output.
// Ports    : clock          - system clock, rising-edge active
//            reset          - asynchronous active-low reset
//            next_PC_select - 0: sequential, 1: load target_PC
//            target_PC      - redirect address
//            PC             - current fetch address
//            misaligned_target - (FETCH_MISALIGN_CHECK_EN only) high for one
//                             cycle after a redirect to a target whose low
//                             two bits are non-zero
// Config   : define FETCH_MISALIGN_CHECK_EN to add misaligned_target.
// Revision : 1.0 - initial release
// ============================================================================
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = FETCH_ADDRESS_BITS,
  parameter int unsigned RESET_PC     = FETCH_RESET_PC,
  parameter int unsigned PC_STEP      = FETCH_PC_STEP
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  output logic [ADDRESS_BITS-1:0] PC
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                    misaligned_target
`endif
);

  localparam logic [ADDRESS_BITS-1:0] RESET_PC_W = ADDRESS_BITS'(RESET_PC);

  logic [ADDRESS_BITS-1:0] next_pc;

  pc_next_mux #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .PC_STEP      (PC_STEP)
  ) u_pc_next_mux (
    .pc        (PC),
    .select    (next_PC_select),
    .target_pc (target_PC),
    .next_pc   (next_pc)
  );

  // Reset acts immediately; any redirect presented during reset is dropped
  // because nothing is latched while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PC <= RESET_PC_W;
    end else begin
      PC <= next_pc;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Flag reflects only the most recent edge: set by a misaligned redirect,
  // cleared by every other edge including sequential ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      misaligned_target <= 1'b0;
    end else begin
      misaligned_target <= (next_PC_select == SEL_TARGET) &&
                           is_misaligned(target_PC[1:0]);
    end
  end
`endif

endmodule : fetch
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch
// Purpose  : Self-checking bench for fetch: directed scenarios with literal
//            expectations followed by randomized select/target/reset traffic,
//            all compared every cycle against a behavioural PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch;

  logic        clock = 1'b1;
  logic        reset;
  logic        next_PC_select;
  logic [15:0] target_PC;
  logic [15:0] PC;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misaligned_target;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int unsigned model_pc  = 0;
  logic        model_mis = 1'b0;

  fetch #(
    .ADDRESS_BITS (16),
    .RESET_PC     (0),
    .PC_STEP      (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .next_PC_select (next_PC_select),
    .target_PC      (target_PC),
    .PC             (PC)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misaligned_target (misaligned_target)
`endif
  );

  // Falling edge at 5, first rising edge at 10.
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the PC is an unsigned 16-bit counter that steps by 4, or jumps
  // to the target when select is high.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_pc  <= 0;
      model_mis <= 1'b0;
    end else if (next_PC_select) begin
      model_pc  <= 32'(target_PC);
      model_mis <= (target_PC % 4) != 0;
    end else begin
      model_pc  <= (model_pc + 4) % 65536;
      model_mis <= 1'b0;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clock) begin
    chk("pc_vs_model", 32'(PC), model_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_vs_model", 32'(misaligned_target), 32'(model_mis));
`endif
  end

  task automatic edge_at(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    next_PC_select = 1'b1;
    target_PC      = 16'h0000;
    #1;
    chk("reset_async", 32'(PC), 32'h0000);

    // Reset held across the edge at t=10 with select high.
    edge_at(1);
    chk("reset_hold", 32'(PC), 32'h0000);

    // Release at t=11, sequential with an ignored target.
    reset          = 1'b1;
    next_PC_select = 1'b0;
    target_PC      = 16'hFF00;
    edge_at(1);
    chk("first_step", 32'(PC), 32'h0004);
    edge_at(10);
    chk("seq_t120", 32'(PC), 32'h002C);

    // Single-edge redirect then two sequential steps.
    next_PC_select = 1'b1;
    edge_at(1);
    chk("redirect", 32'(PC), 32'hFF00);
    next_PC_select = 1'b0;
    edge_at(2);
    chk("after_redirect", 32'(PC), 32'hFF08);

    // Wrap-around.
    target_PC      = 16'hFFFC;
    next_PC_select = 1'b1;
    edge_at(1);
    chk("wrap_load", 32'(PC), 32'hFFFC);
    next_PC_select = 1'b0;
    edge_at(1);
    chk("wrap_zero", 32'(PC), 32'h0000);

    // Mid-run asynchronous reset at PC=0020.
    edge_at(8);
    chk("pre_reset", 32'(PC), 32'h0020);
    #2 reset = 1'b0;
    #1 chk("mid_reset", 32'(PC), 32'h0000);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    chk("post_reset", 32'(PC), 32'h0004);

    // Held select reloads the same target.
    target_PC      = 16'h1234;
    next_PC_select = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_at(1);
      chk("held_select", 32'(PC), 32'h1234);
    end
    next_PC_select = 1'b0;
    edge_at(1);
    chk("held_release", 32'(PC), 32'h1238);

    // Misaligned target: loaded unmodified.
    target_PC      = 16'h0102;
    next_PC_select = 1'b1;
    edge_at(1);
    chk("misaligned_load", 32'(PC), 32'h0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag_set", 32'(misaligned_target), 32'h1);
`endif
    next_PC_select = 1'b0;
    edge_at(1);
    chk("misaligned_step", 32'(PC), 32'h0106);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag_clear", 32'(misaligned_target), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      @(posedge clock);
      #2;
      next_PC_select = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0:       target_PC = 16'hFFFC;
        1:       target_PC = 16'hFFF8;
        default: target_PC = 16'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch
`default_nettype wire
